// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, classifies each
// full scan as none/one/multi key, debounces presses and releases, emits one code per press.
//
// state   | meaning
// IDLE    | no key accepted, waiting for a single-key scan
// CONFIRM | candidate key seen, counting identical consecutive scans
// HELD    | key accepted, counting consecutive empty scans for release
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clkot,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] datokey,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW:0]   DBC_LAST   = (BW + 1)'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2
    } state_t;

    logic [3:0]    row_meta_q, row_meta_d;
    logic [3:0]    row_sync_q, row_sync_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    acc_cnt_q, acc_cnt_d;
    logic [3:0]    acc_code_q, acc_code_d;
    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [BW-1:0] dbc_q, dbc_d;
    logic [3:0]    col_out_q, col_out_d;
    logic [3:0]    datokey_q, datokey_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    logic [3:0] pressed;
    logic [2:0] row_ones;
    logic [2:0] cnt_sum;
    logic [1:0] cnt_sat;
    logic [3:0] row_code;
    logic [3:0] scan_code;
    logic       sample;
    logic       scan_done;
    logic       one_key;
    logic [BW:0] dbc_inc;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    always_comb begin
        pressed  = ~row_sync_q;
        row_ones = 3'(pressed[0]) + 3'(pressed[1]) + 3'(pressed[2]) + 3'(pressed[3]);
        row_code = 4'h0;
        for (int r = 0; r < 4; r++) begin
            if (pressed[r]) row_code = key_code(2'(r), col_idx_q);
        end
        // Key count saturates at 2: anything beyond one key is simply "multi".
        cnt_sum   = {1'b0, acc_cnt_q} + row_ones;
        cnt_sat   = (cnt_sum >= 3'd2) ? 2'd2 : cnt_sum[1:0];
        scan_code = (acc_cnt_q == 2'd0) ? row_code : acc_code_q;
        sample    = (dwell_q == DWELL_LAST);
        scan_done = sample && (col_idx_q == 2'd3);
        one_key   = scan_done && (cnt_sat == 2'd1);
        dbc_inc   = {1'b0, dbc_q} + (BW + 1)'(1);

        row_meta_d  = row_in;
        row_sync_d  = row_meta_q;
        dwell_d     = dwell_q;
        col_idx_d   = col_idx_q;
        acc_cnt_d   = acc_cnt_q;
        acc_code_d  = acc_code_q;
        state_d     = state_q;
        cand_d      = cand_q;
        dbc_d       = dbc_q;
        datokey_d   = datokey_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        if (sample) begin
            dwell_d   = '0;
            col_idx_d = col_idx_q + 2'd1;
            if (col_idx_q == 2'd3) begin
                acc_cnt_d  = 2'd0;
                acc_code_d = 4'h0;
            end else begin
                acc_cnt_d  = cnt_sat;
                acc_code_d = scan_code;
            end
        end else begin
            dwell_d = dwell_q + DW'(1);
        end
        col_out_d = ~(4'b0001 << col_idx_d);

        if (scan_done) begin
            case (state_q)
                IDLE: begin
                    dbc_d = '0;
                    if (one_key) begin
                        cand_d = scan_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            datokey_d   = scan_code;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            state_d     = HELD;
                        end else begin
                            dbc_d   = BW'(1);
                            state_d = CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (one_key && (scan_code == cand_q)) begin
                        if (dbc_inc >= DBC_LAST) begin
                            datokey_d   = cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            dbc_d       = '0;
                            state_d     = HELD;
                        end else begin
                            dbc_d = dbc_inc[BW-1:0];
                        end
                    end else if (one_key) begin
                        cand_d = scan_code;
                        dbc_d  = BW'(1);
                    end else begin
                        dbc_d   = '0;
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    // Any key activity, including a different key, restarts the release count.
                    if (cnt_sat == 2'd0) begin
                        if (dbc_inc >= DBC_LAST) begin
                            key_held_d = 1'b0;
                            dbc_d      = '0;
                            state_d    = IDLE;
                        end else begin
                            dbc_d = dbc_inc[BW-1:0];
                        end
                    end else begin
                        dbc_d = '0;
                    end
                end
                default: begin
                    dbc_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clkot or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q  <= 4'b1111;
            row_sync_q  <= 4'b1111;
            dwell_q     <= '0;
            col_idx_q   <= 2'd0;
            acc_cnt_q   <= 2'd0;
            acc_code_q  <= 4'h0;
            state_q     <= IDLE;
            cand_q      <= 4'h0;
            dbc_q       <= '0;
            col_out_q   <= 4'b1110;
            datokey_q   <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_meta_q  <= row_meta_d;
            row_sync_q  <= row_sync_d;
            dwell_q     <= dwell_d;
            col_idx_q   <= col_idx_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_code_q  <= acc_code_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            dbc_q       <= dbc_d;
            col_out_q   <= col_out_d;
            datokey_q   <= datokey_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col_out   = col_out_q;
    assign datokey   = datokey_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model plus a scoreboard of expected
// key codes and the cycle at which each strobe must appear.
module tb_keypad_scanner;

    localparam int SD   = 4;
    localparam int DS   = 2;
    localparam int SCAN = 4 * SD;

    typedef struct {
        logic [3:0] code;
        int         cyc;
    } exp_t;

    logic       clkot = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] datokey;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys = 16'h0;
    int          cyc;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clkot     (clkot),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .datokey   (datokey),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clkot = ~clkot;

    always @(posedge clkot or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    always @(negedge clkot) begin
        if (rst_n && key_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: datokey=%h at cyc %0d, required no pulse", datokey, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (datokey !== e.code || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pulse: datokey=%h at cyc %0d, required %h at cyc %0d",
                             datokey, cyc, e.code, e.cyc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic next_scan();
        @(negedge clkot);
        while (cyc % SCAN != 0) @(negedge clkot);
    endtask

    task automatic wait_scans(input int n);
        repeat (n * SCAN) @(negedge clkot);
    endtask

    task automatic push_exp(input logic [3:0] code, input int at);
        exp_t e;
        e.code = code;
        e.cyc  = at;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        repeat (3) @(negedge clkot);
        rst_n = 1'b1;
        repeat (6) @(negedge clkot);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (col_out !== 4'b1110 || datokey !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: col=%b key=%h v=%b h=%b, required 1110 0 0 0",
                     col_out, datokey, key_valid, key_held);
        end
        @(negedge clkot);
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clkot);
            exp_col = 4'b1111 ^ (4'b0001 << ((k / SD) % 4));
            checks++;
            if (col_out !== exp_col) begin
                errors++;
                $display("FAIL col_step: cyc %0d col=%b, required %b", k, col_out, exp_col);
            end
        end
    endtask

    task automatic test_single_press();
        int t;
        next_scan();
        t = cyc;
        keys[5] = 1'b1;
        push_exp(4'h5, t + 2 * SCAN);
        wait_scans(10);
        checks++;
        if (sb_q.size() != 0 || key_held !== 1'b1) begin
            errors++;
            $display("FAIL press5_held: pending=%0d held=%b, required 0 1", sb_q.size(), key_held);
        end
        keys = 16'h0;
        repeat (2 * SCAN - 1) @(negedge clkot);
        checks++;
        if (key_held !== 1'b1) begin
            errors++;
            $display("FAIL release_early: held=%b, required 1", key_held);
        end
        @(negedge clkot);
        checks++;
        if (key_held !== 1'b0) begin
            errors++;
            $display("FAIL release: held=%b, required 0", key_held);
        end
    endtask

    task automatic test_back_to_back();
        int t;
        next_scan();
        t = cyc;
        keys[12] = 1'b1;
        push_exp(4'hE, t + 2 * SCAN);
        wait_scans(3);
        keys = 16'h0;
        wait_scans(1);
        checks++;
        if (datokey !== 4'hE) begin
            errors++;
            $display("FAIL gap_hold: datokey=%h, required e", datokey);
        end
        wait_scans(2);
        checks++;
        if (datokey !== 4'hE || key_held !== 1'b0) begin
            errors++;
            $display("FAIL gap_end: datokey=%h held=%b, required e 0", datokey, key_held);
        end
        t = cyc;
        keys[14] = 1'b1;
        push_exp(4'hF, t + 2 * SCAN);
        wait_scans(3);
        keys = 16'h0;
        wait_scans(3);
        checks++;
        if (sb_q.size() != 0 || datokey !== 4'hF) begin
            errors++;
            $display("FAIL hash: pending=%0d datokey=%h, required 0 f", sb_q.size(), datokey);
        end
    endtask

    task automatic test_bounce();
        next_scan();
        for (int i = 0; i < 4; i++) begin
            keys[9] = (i % 2 == 0);
            wait_scans(1);
            checks++;
            if (key_held !== 1'b0) begin
                errors++;
                $display("FAIL bounce_held: scan %0d held=%b, required 0", i, key_held);
            end
        end
        keys = 16'h0;
        wait_scans(3);
        checks++;
        if (key_held !== 1'b0 || datokey !== 4'hF) begin
            errors++;
            $display("FAIL bounce_end: held=%b datokey=%h, required 0 f", key_held, datokey);
        end
    endtask

    task automatic test_multi_key();
        int t;
        next_scan();
        keys[0] = 1'b1;
        keys[1] = 1'b1;
        wait_scans(5);
        checks++;
        if (key_held !== 1'b0) begin
            errors++;
            $display("FAIL multi_held: held=%b, required 0", key_held);
        end
        keys[0] = 1'b0;
        t = cyc;
        push_exp(4'h2, t + 2 * SCAN);
        wait_scans(4);
        keys = 16'h0;
        wait_scans(3);
        checks++;
        if (sb_q.size() != 0 || datokey !== 4'h2) begin
            errors++;
            $display("FAIL multi_then_2: pending=%0d datokey=%h, required 0 2", sb_q.size(), datokey);
        end
    endtask

    task automatic test_reset_mid_hold();
        int t;
        int n;
        next_scan();
        t = cyc;
        keys[13] = 1'b1;
        push_exp(4'h0, t + 2 * SCAN);
        n = 0;
        while (key_held !== 1'b1 && n < 100) begin
            @(negedge clkot);
            n++;
        end
        checks++;
        if (key_held !== 1'b1) begin
            errors++;
            $display("FAIL hold0_timeout: held=%b, required 1", key_held);
        end
        repeat (5) @(negedge clkot);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (col_out !== 4'b1110 || datokey !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: col=%b key=%h v=%b h=%b, required 1110 0 0 0",
                     col_out, datokey, key_valid, key_held);
        end
        @(negedge clkot);
        rst_n = 1'b1;
        push_exp(4'h0, 2 * SCAN);
        wait_scans(3);
        checks++;
        if (sb_q.size() != 0 || key_held !== 1'b1) begin
            errors++;
            $display("FAIL reemit: pending=%0d held=%b, required 0 1", sb_q.size(), key_held);
        end
        keys = 16'h0;
        wait_scans(3);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_back_to_back();
        test_bounce();
        test_multi_key();
        test_reset_mid_hold();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
